// File: rtl/tile_data_mem_responder_pkg.sv
// Shared CGRA definitions for the tile <-> data-memory interface.
package cgra_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;

  localparam logic DMEM_CNTRL_WRITE = 1'b1;
  localparam logic DMEM_CNTRL_READ  = 1'b0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/tile_data_mem_responder_if.sv
// Tile-row request/response bundle for one data-memory bank.
interface tile_data_mem_responder_if #(
  parameter int NUM_TILES = 4,
  parameter int ADDR_W    = cgra_pkg::DMEM_ADDR_W,
  parameter int DATA_W    = cgra_pkg::DMEM_DATA_W
);

  logic [NUM_TILES-1:0]        data_mem_valid;
  logic [NUM_TILES-1:0]        data_mem_cntrl;
  logic [NUM_TILES*ADDR_W-1:0] data_mem_wrt_addr;
  logic [NUM_TILES*DATA_W-1:0] data_mem_wrt_data;
  logic [NUM_TILES-1:0]        data_mem_ready;
  logic [NUM_TILES*DATA_W-1:0] data_from_mem;
  logic [NUM_TILES-1:0]        data_valid_from_mem;

  modport master (
    output data_mem_valid, data_mem_cntrl, data_mem_wrt_addr, data_mem_wrt_data,
    input  data_mem_ready, data_from_mem, data_valid_from_mem
  );

  modport slave (
    input  data_mem_valid, data_mem_cntrl, data_mem_wrt_addr, data_mem_wrt_data,
    output data_mem_ready, data_from_mem, data_valid_from_mem
  );

endinterface

// File: rtl/tile_data_mem_responder_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_data_mem_responder.sv
// Data-memory bank responder: round-robin tile arbitration, single-port array, 2-cycle reads.
// Define DMEM_INIT_CLEAR_EN to zero the array during INIT after every reset.
module tile_data_mem_responder
  import cgra_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int DEPTH     = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  tile_data_mem_responder_if.slave   bus,
  output logic                       init_done,
  output logic                       addr_err
);

  localparam int TW = $clog2(NUM_TILES);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  // Without clearing, the reset cycle itself is the INIT cycle, so the
  // register reloads straight into RUN and reset gates the outputs.
`ifdef DMEM_INIT_CLEAR_EN
  localparam dmem_state_e RESET_STATE = INIT;
`else
  localparam dmem_state_e RESET_STATE = RUN;
`endif

  dmem_state_e state_q, state_d;
  logic        run;

  logic [TW-1:0]                    rr_ptr_q;
  logic [TW-1:0]                    gnt_idx;
  logic [NUM_TILES-1:0]             gnt;
  logic [NUM_TILES-1:0]             req;
  logic                             accept;
  logic [NUM_TILES-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_TILES-1:0][DATA_W-1:0] req_data;
  logic [ADDR_W-1:0]                acc_addr;
  logic [DATA_W-1:0]                acc_data;
  logic                             acc_cntrl;
  logic                             acc_oor;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [IW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic                             s1_valid_q;
  logic [TW-1:0]                    s1_tile_q;
  logic [IW-1:0]                    s1_idx_q;
  logic                             s1_oor_q;
  logic [NUM_TILES-1:0][DATA_W-1:0] resp_q;
  logic [NUM_TILES-1:0]             resp_vld_q;

`ifdef DMEM_INIT_CLEAR_EN
  logic [IW-1:0] sweep_q;

  always_ff @(posedge clk) begin
    if (reset)                 sweep_q <= '0;
    else if (state_q == INIT)  sweep_q <= sweep_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    run       = 1'b0;
    init_done = 1'b0;
    unique case (state_q)
      INIT: begin
`ifdef DMEM_INIT_CLEAR_EN
        if (sweep_q == IW'(DEPTH - 1)) state_d = RUN;
`else
        state_d = RUN;
`endif
      end
      RUN: begin
        run       = !reset;
        init_done = !reset;
      end
    endcase
  end

  assign req = bus.data_mem_valid & {NUM_TILES{run}};

  rr_arbiter #(.N(NUM_TILES)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.data_mem_ready = gnt;
  assign accept             = |gnt;
  assign req_addr           = bus.data_mem_wrt_addr;
  assign req_data           = bus.data_mem_wrt_data;
  assign acc_addr           = req_addr[gnt_idx];
  assign acc_data           = req_data[gnt_idx];
  assign acc_cntrl          = bus.data_mem_cntrl[gnt_idx];
  assign acc_oor            = {1'b0, acc_addr} >= DEPTH_LIM;

  always_comb begin
    mem_we    = accept && (acc_cntrl == DMEM_CNTRL_WRITE) && !acc_oor;
    mem_waddr = acc_addr[IW-1:0];
    mem_wdata = acc_data;
`ifdef DMEM_INIT_CLEAR_EN
    if (state_q == INIT && !reset) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_q;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Stage 1 latches the accepted read; stage 2 loads the tile's holding register and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      addr_err   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_tile_q  <= '0;
      s1_idx_q   <= '0;
      s1_oor_q   <= 1'b0;
      resp_q     <= '0;
      resp_vld_q <= '0;
    end else begin
      s1_valid_q <= accept && (acc_cntrl == DMEM_CNTRL_READ);
      if (accept) begin
        s1_tile_q <= gnt_idx;
        s1_idx_q  <= acc_addr[IW-1:0];
        s1_oor_q  <= acc_oor;
        rr_ptr_q  <= (gnt_idx == TW'(NUM_TILES - 1)) ? '0 : gnt_idx + 1'b1;
        if (acc_oor) addr_err <= 1'b1;
      end
      resp_vld_q <= '0;
      if (s1_valid_q) begin
        resp_q[s1_tile_q]     <= s1_oor_q ? '0 : mem[s1_idx_q];
        resp_vld_q[s1_tile_q] <= 1'b1;
      end
    end
  end

  assign bus.data_from_mem       = resp_q;
  assign bus.data_valid_from_mem = resp_vld_q;

endmodule

// File: tb/tb_tile_data_mem_responder.sv
// Directed bench: a DEPTH=256 responder for the main paths, a DEPTH=200 one for out-of-range.
module tb_tile_data_mem_responder;
  import cgra_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [3:0]       a_valid, a_cntrl, b_valid, b_cntrl;
  logic [3:0][7:0]  a_addr, b_addr;
  logic [3:0][31:0] a_wdata, b_wdata;
  logic [3:0]       a_ready, a_dvalid, b_ready, b_dvalid;
  logic [3:0][31:0] a_dout, b_dout;
  logic             a_init_done, a_addr_err, b_init_done, b_addr_err;

  tile_data_mem_responder_if #(.NUM_TILES(4), .ADDR_W(8), .DATA_W(32)) bus_a ();
  tile_data_mem_responder_if #(.NUM_TILES(4), .ADDR_W(8), .DATA_W(32)) bus_b ();

  assign bus_a.data_mem_valid    = a_valid;
  assign bus_a.data_mem_cntrl    = a_cntrl;
  assign bus_a.data_mem_wrt_addr = a_addr;
  assign bus_a.data_mem_wrt_data = a_wdata;
  assign a_ready                 = bus_a.data_mem_ready;
  assign a_dvalid                = bus_a.data_valid_from_mem;
  assign a_dout                  = bus_a.data_from_mem;

  assign bus_b.data_mem_valid    = b_valid;
  assign bus_b.data_mem_cntrl    = b_cntrl;
  assign bus_b.data_mem_wrt_addr = b_addr;
  assign bus_b.data_mem_wrt_data = b_wdata;
  assign b_ready                 = bus_b.data_mem_ready;
  assign b_dvalid                = bus_b.data_valid_from_mem;
  assign b_dout                  = bus_b.data_from_mem;

  tile_data_mem_responder #(.NUM_TILES(4), .ADDR_W(8), .DATA_W(32), .DEPTH(256)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a.slave),
    .init_done (a_init_done),
    .addr_err  (a_addr_err)
  );

  tile_data_mem_responder #(.NUM_TILES(4), .ADDR_W(8), .DATA_W(32), .DEPTH(200)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b.slave),
    .init_done (b_init_done),
    .addr_err  (b_addr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one request from tile t, checks its grant, returns in the cycle after accept.
  task automatic issue(input bit on_b, input logic [1:0] t, input logic wr,
                       input logic [7:0] addr, input logic [31:0] wdata, input string tag);
    logic [3:0] onehot;
    onehot = 4'b0001 << t;
    if (on_b) begin
      b_valid = onehot;
      b_cntrl = (wr == DMEM_CNTRL_WRITE) ? onehot : 4'b0000;
      b_addr[t] = addr;
      b_wdata[t] = wdata;
    end else begin
      a_valid = onehot;
      a_cntrl = (wr == DMEM_CNTRL_WRITE) ? onehot : 4'b0000;
      a_addr[t] = addr;
      a_wdata[t] = wdata;
    end
    #1;
    check(tag, on_b ? b_ready : a_ready, onehot);
    @(negedge clk);
    a_valid = '0;
    b_valid = '0;
  endtask

  int unsigned pulses [4];
  logic [3:0]  exp4;

  initial begin
    reset = 1'b1;
    a_valid = '0; a_cntrl = '0; a_addr = '0; a_wdata = '0;
    b_valid = '0; b_cntrl = '0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", a_ready, 0);
    check("rst_dvalid", a_dvalid, 0);
    check("rst_dout0", a_dout[0], 0);
    check("rst_init_done", a_init_done, 0);
    check("rst_addr_err", a_addr_err, 0);
    check("rst_b_addr_err", b_addr_err, 0);

    reset = 1'b0;
    #1;
`ifdef DMEM_INIT_CLEAR_EN
    check("init_low", a_init_done, 0);
    repeat (255) @(negedge clk);
    check("init_low_last", a_init_done, 0);
    @(negedge clk);
    check("init_rise", a_init_done, 1);
    check("init_b_done", b_init_done, 1);
`else
    check("init_rise", a_init_done, 1);
    issue(1'b0, 2'd0, DMEM_CNTRL_WRITE, 8'h10, 32'h0, "wr10_gnt");
`endif

    // read of 0x10 by tile 0: pulse exactly at accept+2
    issue(1'b0, 2'd0, DMEM_CNTRL_READ, 8'h10, 32'h0, "rd10_gnt");
    check("rd10_early", a_dvalid, 0);
    @(negedge clk);
    check("rd10_pulse", a_dvalid, 4'b0001);
    check("rd10_data", a_dout[0], 32'h0);
    @(negedge clk);
    check("rd10_pulse_end", a_dvalid, 0);

    // read-after-write across tiles
    issue(1'b0, 2'd1, DMEM_CNTRL_WRITE, 8'h20, 32'hDEADBEEF, "wr20_gnt");
    issue(1'b0, 2'd2, DMEM_CNTRL_READ, 8'h20, 32'h0, "rd20_gnt");
    check("rd20_early", a_dvalid, 0);
    @(negedge clk);
    check("rd20_pulse", a_dvalid, 4'b0100);
    check("rd20_data", a_dout[2], 32'hDEADBEEF);

    // preload 0x40..0x43 from tile 3, leaving rr_ptr at 0
    for (int i = 0; i < 4; i++)
      issue(1'b0, 2'd3, DMEM_CNTRL_WRITE, 8'(8'h40 + i), 32'(32'h100 + i), "pre_gnt");

    for (int t = 0; t < 4; t++) begin
      a_addr[t] = 8'(8'h40 + t);
      pulses[t] = 0;
    end
    a_cntrl = '0;
    a_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) a_valid = '0;
      #1;
      exp4 = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      check("rr_gnt", a_ready, exp4);
      exp4 = (c >= 2) ? 4'(1 << ((c - 2) % 4)) : 4'b0000;
      check("rr_pulse", a_dvalid, exp4);
      if (c >= 2) check("rr_data", a_dout[(c - 2) % 4], 32'(32'h100 + (c - 2) % 4));
      for (int t = 0; t < 4; t++) if (a_dvalid[t]) pulses[t]++;
      @(negedge clk);
    end
    for (int t = 0; t < 4; t++) check("rr_pulse_count", pulses[t], 2);

    // back-to-back reads by tile 0
    issue(1'b0, 2'd0, DMEM_CNTRL_WRITE, 8'h01, 32'hA, "pre_a_gnt");
    issue(1'b0, 2'd0, DMEM_CNTRL_WRITE, 8'h02, 32'hB, "pre_b_gnt");
    issue(1'b0, 2'd0, DMEM_CNTRL_WRITE, 8'h03, 32'hC, "pre_c_gnt");
    a_cntrl = '0;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        a_valid = 4'b0001;
        a_addr[0] = 8'(c + 1);
      end else begin
        a_valid = '0;
      end
      #1;
      if (c < 3) check("b2b_gnt", a_ready, 4'b0001);
      check("b2b_pulse", a_dvalid, (c >= 2 && c < 5) ? 4'b0001 : 4'b0000);
      if (c >= 2 && c < 5) check("b2b_data", a_dout[0], 32'(32'hA + c - 2));
      @(negedge clk);
    end

    // out-of-range handling on the DEPTH=200 instance
    check("b_err_init", b_addr_err, 0);
    issue(1'b1, 2'd3, DMEM_CNTRL_WRITE, 8'hC7, 32'h1234, "b_wr_c7_gnt");
    check("b_err_inrange", b_addr_err, 0);
    issue(1'b1, 2'd3, DMEM_CNTRL_READ, 8'hC7, 32'h0, "b_rd_c7_gnt");
    @(negedge clk);
    check("b_rd_c7_pulse", b_dvalid, 4'b1000);
    check("b_rd_c7_data", b_dout[3], 32'h1234);
    issue(1'b1, 2'd3, DMEM_CNTRL_WRITE, 8'hF0, 32'h55, "b_wr_f0_gnt");
    check("b_err_set", b_addr_err, 1);
    issue(1'b1, 2'd3, DMEM_CNTRL_READ, 8'hF0, 32'h0, "b_rd_f0_gnt");
    check("b_rd_f0_early", b_dvalid, 0);
    @(negedge clk);
    check("b_rd_f0_pulse", b_dvalid, 4'b1000);
    check("b_rd_f0_data", b_dout[3], 32'h0);
    @(negedge clk);
    check("b_err_sticky", b_addr_err, 1);

    // reset the cycle after a read accept
    issue(1'b0, 2'd0, DMEM_CNTRL_READ, 8'h02, 32'h0, "rst_rd_gnt");
    reset = 1'b1;
    a_valid = 4'b0010;
    a_cntrl = '0;
    #1;
    check("rst_gate_ready", a_ready, 0);
    @(negedge clk);
    check("midrst_dvalid", a_dvalid, 0);
    check("midrst_ready", a_ready, 0);
    check("midrst_dout0", a_dout[0], 0);
    check("midrst_dout2", a_dout[2], 0);
    check("midrst_init_done", a_init_done, 0);
    check("midrst_b_addr_err", b_addr_err, 0);
    check("midrst_b_dout3", b_dout[3], 0);
    a_valid = '0;
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
